// File: rtl/switch_cfg_loader.sv
// rtl/switch_cfg_loader.sv - checksummed switch-matrix config frame loader
module switch_cfg_loader #(
   parameter int NWORDS = 18
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  cfg_valid,
   input  logic [5:0]            cfg_data,
   output logic                  cfg_ready,
   output logic [NWORDS*6-1:0]   cfg_bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CW = $clog2(NWORDS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, CSUM, COMMIT} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [5:0]      acc;
   logic            rng;
   logic [5:0]      shadow [NWORDS];
   logic            xfer;
   logic            word_bad;
   logic [2:0]      side;
   logic [2:0]      idx;

   // Handshake: start wins over any offered word so an abort never half-consumes data
   always_comb begin
      cfg_ready = ((state == LOAD) || (state == CSUM)) && !start;
      busy      = (state != IDLE);
      xfer      = cfg_valid && cfg_ready;
   end

   // Range check for a data word: side 0 leaves the index unused
   always_comb begin
      side     = cfg_data[2:0];
      idx      = cfg_data[5:3];
      word_bad = 1'b0;
      if (side > 3'd4)
         word_bad = 1'b1;
      else if (((side == 3'd1) || (side == 3'd3)) && (idx > 3'd4))
         word_bad = 1'b1;
      else if (((side == 3'd2) || (side == 3'd4)) && (idx > 3'd3))
         word_bad = 1'b1;
   end

   // Frame FSM: shadow fills during LOAD, cfg_bus only updates at the close of COMMIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         rng     <= 1'b0;
         err     <= 1'b0;
         done    <= 1'b0;
         cfg_bus <= '0;
         for (int i = 0; i < NWORDS; i++)
            shadow[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  cnt   <= '0;
                  acc   <= '0;
                  rng   <= 1'b0;
                  err   <= 1'b0;
               end
            end
            LOAD: begin
               if (start) begin
                  cnt <= '0;
                  acc <= '0;
                  rng <= 1'b0;
                  err <= 1'b0;
               end else if (xfer) begin
                  shadow[cnt] <= cfg_data;
                  acc         <= acc ^ cfg_data;
                  rng         <= rng | word_bad;
                  cnt         <= cnt + CW'(1);
                  if (cnt == CW'(NWORDS - 1))
                     state <= CSUM;
               end
            end
            CSUM: begin
               if (start) begin
                  state <= LOAD;
                  cnt   <= '0;
                  acc   <= '0;
                  rng   <= 1'b0;
                  err   <= 1'b0;
               end else if (xfer) begin
                  if ((cfg_data == acc) && !rng) begin
                     state <= COMMIT;
                  end else begin
                     state <= IDLE;
                     err   <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               for (int i = 0; i < NWORDS; i++)
                  cfg_bus[i*6 +: 6] <= shadow[i];
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_cfg_loader.sv
// tb/tb_switch_cfg_loader.sv - directed frame vectors for switch_cfg_loader
module tb_switch_cfg_loader;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [5:0]    cfg_data = 6'd0;
   logic          cfg_ready;
   logic [107:0]  cfg_bus;
   logic          busy;
   logic          done;
   logic          err;

   int total = 0;
   int bad = 0;
   logic [107:0] exp_bus = '0;

   typedef struct {
      logic [5:0] w0;
      int         widx;
      logic [5:0] wval;
      logic [5:0] csum;
      bit         gaps;
      bit         sic;
      bit         ok;
   } vec_t;

   vec_t vecs [8];

   switch_cfg_loader #(.NWORDS(18)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_bus(cfg_bus),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] word_of(input vec_t v, input int k);
      if (k == 0) return v.w0;
      if (k == 18) return v.csum;
      if (k == v.widx) return v.wval;
      return 6'd0;
   endfunction

   function automatic logic [107:0] pack(input vec_t v);
      logic [107:0] b = '0;
      b[5:0] = v.w0;
      b[v.widx*6 +: 6] = v.wval;
      return b;
   endfunction

   task automatic feed(input vec_t v, input int n, input bit gaps);
      int k = 0;
      int budget = 0;
      while (k < n && budget < 400) begin
         @(negedge clk);
         budget++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            cfg_valid = 1'b0;
         end else begin
            cfg_valid = 1'b1;
            cfg_data  = word_of(v, k);
         end
         #1;
         if (cfg_valid && cfg_ready) k++;
      end
      if (k < n) chk("feed_timeout", 108'(k), 108'(n));
   endtask

   task automatic do_frame(input vec_t v, input bit with_start);
      if (with_start) begin
         @(negedge clk);
         start = 1'b1;
         cfg_valid = 1'b0;
         @(negedge clk);
         start = 1'b0;
         chk("err_cleared_by_start", 108'(err), 108'(0));
         chk("busy_in_load", 108'(busy), 108'(1));
      end
      feed(v, 19, v.gaps);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("done_not_early", 108'(done), 108'(0));
      if (v.ok) begin
         chk("busy_in_commit", 108'(busy), 108'(1));
         if (v.sic) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         exp_bus = pack(v);
         chk("done_pulse", 108'(done), 108'(1));
         chk("idle_after_commit", 108'(busy), 108'(0));
         chk("bus_committed", cfg_bus, exp_bus);
         chk("err_low_good", 108'(err), 108'(0));
      end else begin
         chk("busy_after_reject", 108'(busy), 108'(0));
         chk("err_set", 108'(err), 108'(1));
         @(negedge clk);
         chk("no_done_reject", 108'(done), 108'(0));
         chk("bus_retained", cfg_bus, exp_bus);
         chk("err_sticky", 108'(err), 108'(1));
      end
      @(negedge clk);
      chk("done_one_cycle", 108'(done), 108'(0));
   endtask

   initial begin
      vec_t p;
      vec_t g;
      vecs[0] = '{6'b001001,  6, 6'b000000, 6'b001001, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{6'b001001,  6, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{6'b001001,  6, 6'b101010, 6'b100011, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{6'b001001,  6, 6'b000101, 6'b001100, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{6'b001001, 17, 6'b011100, 6'b010101, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{6'b001001,  1, 6'b100001, 6'b101000, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{6'b001001, 11, 6'b100010, 6'b101011, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{6'b011011, 10, 6'b011100, 6'b000111, 1'b0, 1'b0, 1'b1};
      p = '{6'b010010, 3, 6'b010001, 6'b000000, 1'b0, 1'b0, 1'b0};
      g = '{6'b001001, 17, 6'b000001, 6'b001000, 1'b1, 1'b0, 1'b1};

      #12;
      chk("rst_bus", cfg_bus, '0);
      chk("rst_ready", 108'(cfg_ready), 108'(0));
      chk("rst_busy", 108'(busy), 108'(0));
      chk("rst_done", 108'(done), 108'(0));
      chk("rst_err", 108'(err), 108'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         do_frame(vecs[i], 1'b1);

      // abort after 7 words, then a full good frame
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(p, 7, 1'b0);
      @(negedge clk);
      start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data = 6'b111111;
      #1;
      chk("abort_ready_forced_low", 108'(cfg_ready), 108'(0));
      chk("abort_busy", 108'(busy), 108'(1));
      @(negedge clk);
      start = 1'b0;
      cfg_valid = 1'b0;
      chk("abort_bus_unchanged", cfg_bus, exp_bus);
      do_frame(g, 1'b0);

      // asynchronous reset mid-frame
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(vecs[4], 10, 1'b0);
      @(negedge clk);
      cfg_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      exp_bus = '0;
      chk("arst_bus", cfg_bus, exp_bus);
      chk("arst_busy", 108'(busy), 108'(0));
      chk("arst_ready", 108'(cfg_ready), 108'(0));
      chk("arst_done", 108'(done), 108'(0));
      chk("arst_err", 108'(err), 108'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_bus", cfg_bus, exp_bus);
      do_frame(vecs[0], 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_cfg_loader.md
SWITCH_CFG_LOADER -- requirements
Module: switch_cfg_loader

Interface
REQ-001 SHALL have parameter NWORDS, default 18, meaning number of 6-bit switch-matrix config words per frame (5 top, 5 bottom, 4 left, 4 right).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begin a new config frame.
REQ-005 SHALL have port cfg_valid  input  1  cfg_data holds a word.
REQ-006 SHALL have port cfg_data  input  6  config word: [5:3] source index, [2:0] source side (0 none, 1 top, 2 right, 3 bottom, 4 left).
REQ-007 SHALL have port cfg_ready  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port cfg_bus  output  108  committed config to the switch matrix.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame commits.
REQ-011 SHALL have port err  output  1  sticky frame-rejected flag.

Function
REQ-012 SHALL pack cfg_bus as top[0..4] bits [29:0], bottom[0..4] [59:30], left[0..3] [83:60], right[0..3] [107:84], 6 bits per entry, lowest index at lowest bits.
REQ-013 SHALL implement states IDLE, LOAD, CSUM, COMMIT.
REQ-014 SHALL transfer a word only on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-015 SHALL drive cfg_ready=1 in LOAD and CSUM only; busy=1 in any state other than IDLE.
REQ-016 IDLE: start=1 -> LOAD, clearing word counter, XOR accumulator, range flag and err.
REQ-017 LOAD: each transfer writes cfg_data to shadow[counter], XORs it into the accumulator, and increments the counter.
REQ-018 LOAD: the transfer with counter = NWORDS-1 moves the state to CSUM.
REQ-019 LOAD: a word SHALL raise the range flag if side > 4, or side in {1,3} with index > 4, or side in {2,4} with index > 3; side 0 ignores the index.
REQ-020 CSUM: the next transfer is the checksum word.
REQ-021 CSUM: if checksum equals the accumulator and the range flag is clear -> COMMIT; otherwise -> IDLE with err=1 and cfg_bus unchanged.
REQ-022 COMMIT: SHALL last exactly one cycle; at its closing edge cfg_bus loads shadow and done=1 for the following cycle; state -> IDLE.
REQ-023 Latency: done SHALL be high in the second cycle after the checksum transfer edge.
REQ-024 start=1 in LOAD or CSUM SHALL abort the frame: restart LOAD with cleared counter, accumulator, range flag and err; any word offered that cycle is not accepted (cfg_ready forced 0).
REQ-025 start in COMMIT SHALL be ignored.
REQ-026 cfg_valid gaps SHALL stall the frame indefinitely without state change.
REQ-027 cfg_bus SHALL change only in COMMIT; a partial or rejected frame never reaches the switch matrix.
REQ-028 err SHALL stay high until the next start or reset.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, cfg_bus all zero (all switches open), cfg_ready=0, busy=0, done=0, err=0, counter and accumulator 0.
REQ-030 Reset mid-frame SHALL discard shadow contents; cfg_bus SHALL stay zero until a full valid frame commits.

Verification
REQ-031 Good frame: start, word0=6'b001001, words 1-17=0, checksum 6'b001001, cfg_valid held high -> 19 transfers, done pulse 2 cycles after the last transfer, cfg_bus[5:0]=6'b001001, rest 0, err=0.
REQ-032 Checksum error: same frame with checksum 6'b000000 -> err=1, no done, cfg_bus retains its prior value, busy=0 after the checksum transfer.
REQ-033 Range error: word 6 (bottom[1]) = 6'b101010 (right, index 5), correct XOR checksum -> err=1, cfg_bus unchanged; repeat with side 3'b101 -> err=1.
REQ-034 Backpressure/abort: random cfg_valid gaps give the same result as REQ-031; start asserted after 7 words followed by a full good frame -> only the second frame commits.
REQ-035 Reset: rst_n pulsed low after 10 words of a frame -> all outputs 0 asynchronously, cfg_bus stays 0, next good frame commits normally.
